// File: rtl/comparator_core_if.sv
// Operand/cascade and serial-result signals of comparator_core.
// The master drives operands and strobes; the slave returns z and the word result.
interface comparator_core_if;
  logic x;
  logic y;
  logic v;
  logic z;
  logic en;
  logic first;
  logic gt;
  logic lt;
  logic eq;
  logic done;

  modport master (
    output x, y, v, en, first,
    input  z, gt, lt, eq, done
  );

  modport slave (
    input  x, y, v, en, first,
    output z, gt, lt, eq, done
  );
endinterface

// File: rtl/comparator_core.sv
// Bit-slice magnitude comparator with combinational cascade output z and an optional
// LSB-first serial word engine, compiled in only when COMPARATOR_SERIAL_EN is defined.
module comparator_core #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  comparator_core_if.slave bus
);

  assign bus.z = (bus.x & ~bus.y) | (~(bus.x ^ bus.y) & bus.v);

`ifdef COMPARATOR_SERIAL_EN
  localparam int unsigned   CntW   = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            r_g;
  logic            r_l;
  logic [CntW-1:0] r_cnt;
  logic            r_gt;
  logic            r_lt;
  logic            r_eq;
  logic            r_done;

  logic            w_accept;
  logic            w_complete;
  logic            w_same;
  logic            w_g_nx;
  logic            w_l_nx;
  logic [CntW-1:0] w_cnt_nx;

  // A bit is taken only as the start of a word or while a word is open and unfinished;
  // a zero count means no word has been started since reset.
  always_comb begin
    w_accept   = bus.en & (bus.first | ((r_cnt != '0) & (r_cnt != CntMax)));
    w_cnt_nx   = bus.first ? CntOne : r_cnt + CntOne;
    w_complete = w_accept & (w_cnt_nx == CntMax);
    w_same     = ~(bus.x ^ bus.y);
    w_g_nx     = (bus.x & ~bus.y) | (w_same & (bus.first ? bus.v : r_g));
    w_l_nx     = (~bus.x & bus.y) | (w_same & ~bus.first & r_l);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g    <= 1'b0;
      r_l    <= 1'b0;
      r_cnt  <= '0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
      r_eq   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_accept) begin
        r_g   <= w_g_nx;
        r_l   <= w_l_nx;
        r_cnt <= w_cnt_nx;
      end
      if (w_complete) begin
        r_gt <= w_g_nx;
        r_lt <= w_l_nx;
        r_eq <= ~w_g_nx & ~w_l_nx;
      end
    end
  end

  assign bus.gt   = r_gt;
  assign bus.lt   = r_lt;
  assign bus.eq   = r_eq;
  assign bus.done = r_done;
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, bus.en, bus.first};

  assign bus.gt   = 1'b0;
  assign bus.lt   = 1'b0;
  assign bus.eq   = 1'b1;
  assign bus.done = 1'b0;
`endif

endmodule

// File: tb/tb_comparator_core.sv
// Scoreboard bench for comparator_core: stimulus queues expected z and word results,
// a negedge monitor pops and compares them. Serial checks follow COMPARATOR_SERIAL_EN.
module tb_comparator_core;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  comparator_core_if u_if ();

  comparator_core #(
    .WIDTH (W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [2:0] exp_q[$];  // {gt, lt, eq} per completed word
  logic       z_q[$];
  logic       prev_done = 1'b0;
  logic [7:0] ztab = 8'b1011_0010;  // z indexed by {x, y, v}

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (z_q.size() != 0) check("z_cascade", {3'b000, u_if.z}, {3'b000, z_q.pop_front()});
`ifdef COMPARATOR_SERIAL_EN
    if (u_if.done === 1'b1) begin
      check("done_pulse_width", {3'b000, prev_done}, 4'b0000);
      if (exp_q.size() == 0) check("unexpected_done", {3'b000, u_if.done}, 4'b0000);
      else check("word_result", {u_if.gt, u_if.lt, u_if.eq, u_if.done},
                 {exp_q.pop_front(), 1'b1});
    end
    prev_done = u_if.done;
`else
    check("tied_outputs", {u_if.gt, u_if.lt, u_if.eq, u_if.done}, 4'b0010);
`endif
  end

  task automatic drive_bit(input logic a, input logic b, input logic vs, input logic f);
    @(posedge clk);
    #1;
    u_if.x     = a;
    u_if.y     = b;
    u_if.v     = vs;
    u_if.en    = 1'b1;
    u_if.first = f;
    z_q.push_back(ztab[{a, b, vs}]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      u_if.en    = 1'b0;
      u_if.first = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic vs,
                           input int nbits, input int gap_at, input int gap_len,
                           input logic [2:0] expv);
    for (int i = 0; i < nbits; i++) begin
      if (i == gap_at) idle(gap_len);
      drive_bit(a[i], b[i], vs, i == 0);
`ifdef COMPARATOR_SERIAL_EN
      if (i == W - 1) exp_q.push_back(expv);
`endif
    end
  endtask

  initial begin
    u_if.x     = 1'b0;
    u_if.y     = 1'b0;
    u_if.v     = 1'b0;
    u_if.en    = 1'b0;
    u_if.first = 1'b0;
    #1 rst = 1'b1;
    #2 check("reset_state", {u_if.gt, u_if.lt, u_if.eq, u_if.done}, 4'b0010);
    @(posedge clk);
    #1 rst = 1'b0;

    // Exhaustive cascade sweep with the serial engine idle
    for (int i = 0; i < 8; i++) begin
      logic [2:0] xyv;
      xyv = 3'(i);
      @(posedge clk);
      #1;
      u_if.x = xyv[2];
      u_if.y = xyv[1];
      u_if.v = xyv[0];
      z_q.push_back(ztab[xyv]);
    end
    idle(2);

    send_word(8'hA5, 8'h5A, 1'b0, 8, -1, 0, 3'b100);
    // Bits past a finished word without first are dropped
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
`ifdef COMPARATOR_SERIAL_EN
    check("held_after_saturation", {u_if.gt, u_if.lt, u_if.eq, u_if.done}, 4'b1000);
`endif

    send_word(8'h3C, 8'h3C, 1'b1, 8, -1, 0, 3'b100);
    idle(2);
    send_word(8'h3C, 8'h3C, 1'b0, 8, -1, 0, 3'b001);
    idle(2);
    send_word(8'h01, 8'h80, 1'b0, 8, 4, 3, 3'b010);
    idle(2);
    send_word(8'h80, 8'h7F, 1'b0, 8, -1, 0, 3'b100);
    idle(2);

    // Abandoned partial word followed immediately by a new first
    send_word(8'hFF, 8'h00, 1'b0, 3, -1, 0, 3'b000);
    send_word(8'h10, 8'h20, 1'b0, 8, -1, 0, 3'b010);
    idle(2);

    // Reset mid-word, then stray bits without first before the next real word
    send_word(8'hFF, 8'h00, 1'b0, 4, -1, 0, 3'b000);
    @(posedge clk);
    #1;
    u_if.en = 1'b0;
    rst     = 1'b1;
    #1 check("async_reset_midword", {u_if.gt, u_if.lt, u_if.eq, u_if.done}, 4'b0010);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_word(8'hFF, 8'h00, 1'b0, 8, -1, 0, 3'b100);
    idle(4);

`ifdef COMPARATOR_SERIAL_EN
    check("pending_results", 4'(exp_q.size()), 4'b0000);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/comparator_core.md
COMPARATOR_CORE -- requirements
Module: comparator

Interface
REQ-001 SHALL expose parameter WIDTH, default 8, serial word length in bits (legal range 1..64).
REQ-002 SHALL expose port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL expose port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL expose port x  input  1  operand A bit.
REQ-005 SHALL expose port y  input  1  operand B bit.
REQ-006 SHALL expose port v  input  1  cascade-in: "lower-order bits say A>B"; also the seed for serial mode.
REQ-007 SHALL expose port z  output  1  combinational cascade-out, A>B over this bit plus lower bits.
REQ-008 SHALL expose port en  input  1  serial bit-valid strobe, one bit of x/y consumed per cycle with en=1.
REQ-009 SHALL expose port first  input  1  marks the LSB of a new serial word, valid only with en=1.
REQ-010 SHALL expose ports gt, lt, eq  output  1 each  registered serial word result.
REQ-011 SHALL expose port done  output  1  one-cycle pulse when a WIDTH-bit word completes.

Function
REQ-012 z SHALL equal (x AND NOT y) OR ((x XNOR y) AND v); purely combinational, no clock dependence.
- Required truth table, xyv -> z: 000->0, 001->1, 010->0, 011->0, 100->1, 101->1, 110->0, 111->1.
REQ-013 Serial comparison SHALL be LSB-first, tracking internal state g (A>B so far) and l (A<B so far).
REQ-014 On en=1 with first=1: g <= x&~y | (x~^y)&v; l <= ~x&y | (x~^y)&~v&0 (v seeds only g; l seeds 0).
REQ-015 On en=1 with first=0: g <= x&~y | (x~^y)&g; l <= ~x&y | (x~^y)&l.
REQ-016 en=0 SHALL hold g, l and the bit counter unchanged; first is ignored when en=0.
REQ-017 The bit counter SHALL load 1 on first, increment on each other en=1 bit, and saturate at WIDTH.
REQ-018 When the en=1 bit that makes the count equal WIDTH is accepted, gt/lt/eq SHALL update on that same edge.
- gt=g_next, lt=l_next, eq=~g_next&~l_next; done SHALL be 1 for exactly the following cycle.
- WIDTH=1: every en&first bit completes a word.
REQ-019 gt/lt/eq SHALL hold until the next completed word; exactly one of them is 1 after any completion.
REQ-020 Extra en=1 bits after saturation without first SHALL be ignored; the word is discarded, with no done pulse and no result change.
REQ-021 first asserted mid-word SHALL abandon the partial word and restart the count at 1; no done pulse for the abandoned word.

Reset
REQ-022 rst=1 SHALL immediately clear g, l, counter, gt, lt and done, and set eq=1; z is unaffected (combinational).
REQ-023 rst asserted mid-word SHALL discard the partial word; after release, the next word begins only on en&first.

Configuration
REQ-024 Macro COMPARATOR_SERIAL_EN SHALL compile in the serial engine (REQ-013..REQ-021).
- Without the macro: gt, lt and done are tied 0, eq is tied 1, en and first are ignored, and no flops are inferred.
- z behaves identically in both builds.

Verification
REQ-025 Sweep all 8 xyv combinations with rst=0 -> z matches the REQ-012 table at each step.
REQ-026 WIDTH=8, serial A=0xA5, B=0x5A, LSB-first, v=0 -> done pulses once; gt=1, lt=0, eq=0.
REQ-027 WIDTH=8, A=B=0x3C, seed v=1 -> gt=1; repeat with v=0 -> eq=1.
REQ-028 WIDTH=8, A=0x01, B=0x80 with en deasserted for 3 cycles mid-word -> lt=1, done after the 8th en bit only.
REQ-029 rst pulse after 4 bits, then a new word A=0xFF, B=0x00 -> no done for the partial word; gt=1 after 8 bits.
REQ-030 Build without COMPARATOR_SERIAL_EN, drive serial traffic -> gt=lt=done=0 and eq=1 constantly; z still correct.
